trace_capture: RTL and testbench

Parametrised execution-trace recorder for the single-cycle datapath. On each retired instruction it snoops the datapath's `result`, `pc` and `opcode` and records them in a circular buffer. It stops a programmable number of entries after a PC/opcode trigger and then drains the window oldest-first over a valid/ready port. It replaces cycle-by-cycle console printing with an in-hardware record that both simulation and FPGA builds can read back.

---
 rtl/trace_pkg.sv | 18 +
 rtl/trace_ram.sv | 18 +
 rtl/trace_capture.sv | 99 +++++++++
 tb/tb_trace_capture.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// trace_pkg: shared state encoding, entry width and rd_data field offsets for trace_capture.
package trace_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, POST = 2'd2, DONE = 2'd3} state_t;
   function automatic int entry_w(input int stamp_w, pc_w, op_w, data_w);
      return stamp_w + pc_w + op_w + data_w;
   endfunction
   // Entry layout from LSB: result, opcode, pc, stamp
   localparam int RESULT_LO = 0;
   function automatic int opcode_lo(input int data_w);
      return data_w;
   endfunction
   function automatic int pc_lo(input int data_w, op_w);
      return data_w + op_w;
   endfunction
   function automatic int stamp_lo(input int data_w, op_w, pc_w);
      return data_w + op_w + pc_w;
   endfunction
endpackage

// File: rtl/trace_ram.sv
// trace_ram: entry store with one synchronous write port and one asynchronous read port.
module trace_ram #(
   parameter int DEPTH = 16,
   parameter int W = 62
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [W-1:0]             wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [W-1:0]             rdata
);
   logic [W-1:0] mem [DEPTH];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
   end
   assign rdata = mem[raddr];
endmodule

// File: rtl/trace_capture.sv
// trace_capture: circular trace buffer that freezes a window around a PC/opcode trigger
// and drains it oldest-first over a valid/ready port.
module trace_capture
   import trace_pkg::*;
#(
   parameter int DATA_W    = 32,
   parameter int PC_W      = 8,
   parameter int OP_W      = 6,
   parameter int DEPTH     = 16,
   parameter int POST_TRIG = 8,
   parameter int STAMP_W   = 16
) (
   input  logic                                              clk,
   input  logic                                              reset,
   input  logic                                              cap_valid,
   input  logic [DATA_W-1:0]                                 cap_result,
   input  logic [PC_W-1:0]                                   cap_pc,
   input  logic [OP_W-1:0]                                   cap_opcode,
   input  logic                                              arm,
   input  logic [PC_W-1:0]                                   trig_pc,
   input  logic                                              trig_pc_en,
   input  logic [OP_W-1:0]                                   trig_op,
   input  logic                                              trig_op_en,
   output logic [1:0]                                        state,
   output logic [$clog2(DEPTH):0]                            count,
   output logic                                              rd_valid,
   input  logic                                              rd_ready,
   output logic [entry_w(STAMP_W, PC_W, OP_W, DATA_W)-1:0]   rd_data
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int EW = entry_w(STAMP_W, PC_W, OP_W, DATA_W);
   localparam logic [CW-1:0] FULL = CW'(DEPTH);
   localparam logic [AW-1:0] PL_INIT = AW'(POST_TRIG);

   state_t              state_q, state_d;
   logic [AW-1:0]       wr_ptr, rd_ptr, post_left;
   logic [CW-1:0]       count_q;
   logic [STAMP_W-1:0]  stamp;
   logic [EW-1:0]       rd_entry;
   logic                match, wr_en, clear, pop;

   assign match = cap_valid && (!trig_pc_en || cap_pc == trig_pc) && (!trig_op_en || cap_opcode == trig_op);
   assign wr_en = cap_valid && (state_q == ARMED || state_q == POST);
   assign clear = arm && (state_q == IDLE || state_q == DONE);
   assign rd_valid = state_q == DONE && count_q != '0;
   assign pop = rd_valid && rd_ready && !arm;
   // Popping decrements count, so wr_ptr - count walks forward through the window
   assign rd_ptr = wr_ptr - count_q[AW-1:0];
   assign rd_data = rd_valid ? rd_entry : '0;
   assign state = state_q;
   assign count = count_q;

   always_ff @(posedge clk) begin
      if (reset) state_q <= IDLE;
      else state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:  if (arm) state_d = ARMED;
         ARMED: if (match) state_d = POST_TRIG == 0 ? DONE : POST;
         POST:  if (cap_valid && post_left == AW'(1)) state_d = DONE;
         DONE:  if (arm) state_d = ARMED;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr    <= '0;
         count_q   <= '0;
         post_left <= '0;
         stamp     <= '0;
      end else begin
         stamp <= stamp + STAMP_W'(1);
         if (clear) begin
            wr_ptr  <= '0;
            count_q <= '0;
         end else if (wr_en) begin
            wr_ptr  <= wr_ptr + AW'(1);
            count_q <= count_q == FULL ? count_q : count_q + CW'(1);
         end else if (pop) begin
            count_q <= count_q - CW'(1);
         end
         if (state_q == ARMED && match) post_left <= PL_INIT;
         else if (state_q == POST && cap_valid) post_left <= post_left - AW'(1);
      end
   end

   trace_ram #(.DEPTH(DEPTH), .W(EW)) u_ram (
      .clk   (clk),
      .we    (wr_en),
      .waddr (wr_ptr),
      .wdata ({stamp, cap_pc, cap_opcode, cap_result}),
      .raddr (rd_ptr),
      .rdata (rd_entry)
   );
endmodule

// File: tb/tb_trace_capture.sv
// tb_trace_capture: table-driven capture/drain scenarios plus hand-written corner sequences.
module tb_trace_capture;
   logic        clk = 0, reset = 1, cap_valid = 0, arm = 0, rd_ready = 0;
   logic [31:0] cap_result = 0;
   logic [7:0]  cap_pc = 0, trig_pc = 0;
   logic [5:0]  cap_opcode = 0, trig_op = 0;
   logic        trig_pc_en = 0, trig_op_en = 0;
   logic [1:0]  st0, st1;
   logic [4:0]  cnt0, cnt1;
   logic        rv0, rv1;
   logic [61:0] rd0, rd1;
   int          total = 0, bad = 0;
   logic [7:0]  pc;
   logic [7:0]  q_pc[$];
   logic [5:0]  q_op[$];
   logic [15:0] q_st[$];
   logic [31:0] q_res[$];

   always #5 clk = ~clk;

   trace_capture #(.POST_TRIG(8)) u0 (
      .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_result(cap_result), .cap_pc(cap_pc),
      .cap_opcode(cap_opcode), .arm(arm), .trig_pc(trig_pc), .trig_pc_en(trig_pc_en),
      .trig_op(trig_op), .trig_op_en(trig_op_en), .state(st0), .count(cnt0),
      .rd_valid(rv0), .rd_ready(rd_ready), .rd_data(rd0));

   trace_capture #(.POST_TRIG(0)) u1 (
      .clk(clk), .reset(reset), .cap_valid(cap_valid), .cap_result(cap_result), .cap_pc(cap_pc),
      .cap_opcode(cap_opcode), .arm(arm), .trig_pc(trig_pc), .trig_pc_en(trig_pc_en),
      .trig_op(trig_op), .trig_op_en(trig_op_en), .state(st1), .count(cnt1),
      .rd_valid(rv1), .rd_ready(rd_ready), .rd_data(rd1));

   typedef struct {
      logic [7:0] tpc;
      logic       tpe;
      logic [5:0] top;
      logic       toe;
      int         gap;
      int         n;
      logic [7:0] first;
      logic [7:0] last;
   } vec_t;
   vec_t vecs[6];

   task automatic chk(input string name, input longint act, input longint exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic capture(input int gap, input bit sel);
      arm = 1;
      step();
      arm = 0;
      pc = 0;
      for (int i = 0; i < 200; i++) begin
         if ((sel ? st1 : st0) == 2'd3) break;
         cap_valid = (i % gap == 0);
         cap_pc = pc;
         cap_opcode = pc[5:0];
         cap_result = {24'hC0FFEE, pc};
         step();
         if (cap_valid) pc++;
      end
      cap_valid = 0;
   endtask

   task automatic drain(input bit sel, input bit bp);
      logic [61:0] d;
      q_pc.delete(); q_op.delete(); q_st.delete(); q_res.delete();
      for (int c = 0; c < 100; c++) begin
         if (!(sel ? rv1 : rv0)) break;
         rd_ready = bp ? (c % 3 == 0) : 1'b1;
         d = sel ? rd1 : rd0;
         if (rd_ready) begin
            q_res.push_back(d[31:0]);
            q_op.push_back(d[37:32]);
            q_pc.push_back(d[45:38]);
            q_st.push_back(d[61:46]);
         end
         step();
      end
      rd_ready = 0;
   endtask

   task automatic stamp_steps(input int gap);
      int errs = 0;
      logic [15:0] diff;
      for (int i = 1; i < q_st.size(); i++) begin
         diff = q_st[i] - q_st[i-1];
         if (diff != 16'(gap)) errs++;
      end
      chk("stamp_step", errs, 0);
   endtask

   initial begin
      vecs[0] = '{8'h10, 1'b1, 6'h00, 1'b0, 1, 16, 8'd9, 8'd24};
      vecs[1] = '{8'h02, 1'b1, 6'h00, 1'b0, 1, 11, 8'd0, 8'd10};
      vecs[2] = '{8'h00, 1'b0, 6'h00, 1'b0, 1,  9, 8'd0, 8'd8};
      vecs[3] = '{8'h10, 1'b1, 6'h00, 1'b0, 3, 16, 8'd9, 8'd24};
      vecs[4] = '{8'h04, 1'b1, 6'h04, 1'b1, 1, 13, 8'd0, 8'd12};
      vecs[5] = '{8'h00, 1'b0, 6'h04, 1'b1, 2, 13, 8'd0, 8'd12};

      step(); step();
      chk("rst_state", st0, 0);
      chk("rst_count", cnt0, 0);
      chk("rst_rd_valid", rv0, 0);
      chk("rst_rd_data", rd0, 0);
      reset = 0;

      cap_valid = 1;
      step(); step(); step();
      cap_valid = 0;
      chk("idle_ignore_state", st0, 0);
      chk("idle_ignore_count", cnt0, 0);

      // arm while ARMED is ignored; reset mid-POST discards everything
      trig_pc = 8'h10; trig_pc_en = 1;
      arm = 1; step(); arm = 0;
      chk("arm_state", st0, 1);
      foreach (vecs[k]) if (k < 2) begin
         cap_valid = 1; cap_pc = 8'h0E + 8'(k); step();
      end
      cap_valid = 0;
      arm = 1; step(); arm = 0;
      chk("arm_in_armed_state", st0, 1);
      chk("arm_in_armed_count", cnt0, 2);
      cap_valid = 1; cap_pc = 8'h10; step();
      cap_pc = 8'h11; step();
      cap_valid = 0;
      chk("post_state", st0, 2);
      chk("post_count", cnt0, 4);
      reset = 1; step(); reset = 0;
      chk("rst_post_state", st0, 0);
      chk("rst_post_count", cnt0, 0);
      chk("rst_post_rv", rv0, 0);

      foreach (vecs[k]) begin
         trig_pc = vecs[k].tpc; trig_pc_en = vecs[k].tpe;
         trig_op = vecs[k].top; trig_op_en = vecs[k].toe;
         capture(vecs[k].gap, 0);
         chk($sformatf("v%0d_state", k), st0, 3);
         chk($sformatf("v%0d_count", k), cnt0, vecs[k].n);
         drain(0, 0);
         chk($sformatf("v%0d_npop", k), q_pc.size(), vecs[k].n);
         if (q_pc.size() > 0) begin
            chk($sformatf("v%0d_first_pc", k), q_pc[0], vecs[k].first);
            chk($sformatf("v%0d_last_pc", k), q_pc[$], vecs[k].last);
            chk($sformatf("v%0d_first_res", k), q_res[0], {24'hC0FFEE, vecs[k].first});
            chk($sformatf("v%0d_last_op", k), q_op[$], {2'b00, vecs[k].last[5:0]});
         end
         stamp_steps(vecs[k].gap);
         chk($sformatf("v%0d_rv_after", k), rv0, 0);
         chk($sformatf("v%0d_rd_after", k), rd0, 0);
         chk($sformatf("v%0d_state_after", k), st0, 3);
      end

      // POST_TRIG=0 instance: DONE on the matching edge
      reset = 1; step(); reset = 0;
      trig_pc_en = 0; trig_op = 6'h04; trig_op_en = 1;
      capture(1, 1);
      chk("pt0_retired", pc, 5);
      chk("pt0_state", st1, 3);
      chk("pt0_count", cnt1, 5);
      drain(1, 0);
      chk("pt0_npop", q_op.size(), 5);
      if (q_op.size() > 0) chk("pt0_last_op", q_op[$], 6'h04);

      // backpressure: rd_ready 1,0,0,1,...
      reset = 1; step(); reset = 0;
      trig_pc = 8'h02; trig_pc_en = 1; trig_op_en = 0;
      capture(1, 0);
      drain(0, 1);
      chk("bp_npop", q_pc.size(), 11);
      begin
         int errs = 0;
         foreach (q_pc[i]) if (q_pc[i] != 8'(i)) errs++;
         chk("bp_order", errs, 0);
      end
      stamp_steps(1);

      // arm coinciding with a pop: arm wins
      capture(1, 0);
      chk("ap_pre_count", cnt0, 11);
      arm = 1; rd_ready = 1; step(); arm = 0; rd_ready = 0;
      chk("ap_state", st0, 1);
      chk("ap_count", cnt0, 0);
      chk("ap_rv", rv0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
